// File: rtl/io_input_scan_pkg.sv
// Shared definitions for the input-port scanner: IO window offsets and the scan FSM encoding.
package io_input_scan_pkg;

  localparam logic [5:0] IO_PORT0 = 6'b100000;
  localparam logic [5:0] IO_PORT1 = 6'b100001;
  localparam logic [5:0] IO_STAT  = 6'b100010;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_P0   = 2'd1,
    S_P1   = 2'd2
  } scan_state_e;

  // Scan FSM register, visible as one struct so checkers can bind to the state directly.
  typedef struct packed {
    scan_state_e state;
    logic [1:0]  sample_en;
  } scan_dbg_t;

endpackage

// File: rtl/io_debounce_ch.sv
// One input channel: two-flop synchroniser, debounce candidate/counter, committed value and sticky change flag.
module io_debounce_ch
  import io_input_scan_pkg::*;
#(
  parameter int DB_CNT = 3,
  parameter int CW     = 8
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic [31:0] raw,
  input  logic        sample_en,
  input  logic        clr,
  output logic [31:0] stable,
  output logic        chg
);

  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CNT - 1);

  logic [31:0]   sync0;
  logic [31:0]   sync1;
  logic [31:0]   cand;
  logic [CW-1:0] cnt;
  logic          set_chg;

  // A commit only flags a change when the value actually differs from what the CPU last saw.
  assign set_chg = sample_en && (sync1 == cand) && (cnt == CNT_MAX) && (cand != stable);

  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      sync0  <= '0;
      sync1  <= '0;
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
      chg    <= 1'b0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      if (sample_en) begin
        if (sync1 != cand) begin
          cand <= sync1;
          cnt  <= '0;
        end else if (cnt == CNT_MAX) begin
          stable <= cand;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
      // Set has priority over a same-cycle read-clear so no change is ever lost.
      if (set_chg) begin
        chg <= 1'b1;
      end else if (clr) begin
        chg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/io_input_scan.sv
// Round-robin scanner for two debounced input ports, with CPU read window, read-clear flags and irq.
module io_input_scan
  import io_input_scan_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DB_CNT   = 3,
  parameter int CW       = 8
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic        irq_en,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  output logic [31:0] io_read_data,
  output logic        irq
);

  localparam logic [CW-1:0] DIV_MAX = CW'(SCAN_DIV - 1);

  scan_dbg_t     fsm;
  logic [CW-1:0] div;
  logic [31:0]   stable0;
  logic [31:0]   stable1;
  logic          chg0;
  logic          chg1;
  logic          clr0;
  logic          clr1;
  logic          addr_unused;

  assign addr_unused = ^{addr[31:8], addr[1:0]};

  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      fsm <= '{state: S_WAIT, sample_en: 2'b00};
      div <= '0;
    end else begin
      case (fsm.state)
        S_WAIT: begin
          if (div == DIV_MAX) begin
            div <= '0;
            fsm <= '{state: S_P0, sample_en: 2'b01};
          end else begin
            div <= div + CW'(1);
          end
        end
        S_P0: fsm <= '{state: S_P1, sample_en: 2'b10};
        S_P1: begin
          fsm <= '{state: S_WAIT, sample_en: 2'b00};
          div <= '0;
        end
        default: begin
          fsm <= '{state: S_WAIT, sample_en: 2'b00};
          div <= '0;
        end
      endcase
    end
  end

  io_debounce_ch #(.DB_CNT(DB_CNT), .CW(CW)) u_ch0 (
    .io_clk    (io_clk),
    .reset     (reset),
    .raw       (in_port0),
    .sample_en (fsm.sample_en[0]),
    .clr       (clr0),
    .stable    (stable0),
    .chg       (chg0)
  );

  io_debounce_ch #(.DB_CNT(DB_CNT), .CW(CW)) u_ch1 (
    .io_clk    (io_clk),
    .reset     (reset),
    .raw       (in_port1),
    .sample_en (fsm.sample_en[1]),
    .clr       (clr1),
    .stable    (stable1),
    .chg       (chg1)
  );

  // rd_en is a one-cycle strobe with no ready: every read completes in the cycle it is presented.
  assign clr0 = rd_en && (addr[7:2] == IO_PORT0);
  assign clr1 = rd_en && (addr[7:2] == IO_PORT1);

  always_comb begin
    io_read_data = '0;
    case (addr[7:2])
      IO_PORT0: io_read_data = stable0;
      IO_PORT1: io_read_data = stable1;
      IO_STAT:  io_read_data = {30'b0, chg1, chg0};
      default:  io_read_data = '0;
    endcase
  end

  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en & (chg0 | chg1);
    end
  end

endmodule
